// File: rtl/debport_arbiter.sv
// Debug header arbiter: shares out_port between NREQ requesters and software.
// Define DEBPORT_ARB_TAG_EN to tag granted bytes with the requester index.
module debport_arbiter #(
  parameter int NREQ    = 4,
  parameter int DATA_W  = 8,
  parameter int DWELL_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [1:0]               address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          ack,
  output logic [DATA_W-1:0]        out_port,
  output logic [1:0]               out_src
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state_q;
  logic               en_q;
  logic               mode_q;
  logic [NREQ-1:0]    mask_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] hold_q;
  logic [DATA_W-1:0]  sw_q;
  logic [1:0]         ptr_q;
  logic [1:0]         last_q;
  logic [15:0]        gcnt_q;
  logic [15:0]        gcnt_d;

  logic               wr;
  logic               wr_ctrl;
  logic               wr_stat;
  logic               kill;
  logic [NREQ-1:0]    cand;
  logic               grant;
  logic [1:0]         win_d;
  logic [1:0]         idx;
  logic               found;
  logic [DATA_W-1:0]  win_byte;
  logic [DWELL_W-1:0] de;
  logic               unused_ok;

  assign wr      = chipselect & ~write_n;
  assign wr_ctrl = wr & (address == 2'd0);
  assign wr_stat = wr & (address == 2'd3);
  // A CTRL write that clears EN must suppress a grant at the same edge
  assign kill    = wr_ctrl & ~writedata[0];
  assign cand    = req & mask_q;
  assign grant   = (state_q == IDLE) & en_q & ~kill & (|cand);
  assign de      = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
  assign win_byte = req_data[int'(win_d)*DATA_W +: DATA_W];
  assign unused_ok = ^{writedata, win_byte};

  always_comb begin
    win_d = '0;
    found = 1'b0;
    idx   = '0;
    if (mode_q) begin
      for (int i = NREQ-1; i >= 0; i--)
        if (cand[i]) win_d = 2'(i);
    end else begin
      for (int i = 1; i <= NREQ; i++) begin
        idx = 2'((int'(ptr_q) + i) % NREQ);
        if (!found && cand[idx]) begin
          found = 1'b1;
          win_d = idx;
        end
      end
    end
  end

  always_comb begin
    gcnt_d = gcnt_q;
    if (wr_stat) gcnt_d = '0;
    if (grant && gcnt_d != 16'hFFFF) gcnt_d = gcnt_d + 16'd1;
  end

  always_comb begin
    readdata = '0;
    unique case (address)
      2'd0: begin
        readdata[0]        = en_q;
        readdata[1]        = mode_q;
        readdata[4 +: NREQ] = mask_q;
      end
      2'd1: readdata[DWELL_W-1:0] = dwell_q;
      2'd2: readdata[DATA_W-1:0]  = sw_q;
      2'd3: begin
        readdata[1:0]  = last_q;
        readdata[4]    = (state_q == HOLD);
        readdata[23:8] = gcnt_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q    <= 1'b0;
      mode_q  <= 1'b0;
      mask_q  <= '0;
      dwell_q <= '0;
      sw_q    <= '0;
      gcnt_q  <= '0;
    end else begin
      gcnt_q <= gcnt_d;
      if (wr_ctrl) begin
        en_q   <= writedata[0];
        mode_q <= writedata[1];
        mask_q <= writedata[4 +: NREQ];
      end
      if (wr && address == 2'd1) dwell_q <= writedata[DWELL_W-1:0];
      if (wr && address == 2'd2) sw_q <= writedata[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      out_port <= '0;
      out_src  <= '0;
      ack      <= '0;
      ptr_q    <= 2'(NREQ-1);
      last_q   <= '0;
    end else begin
      ack <= '0;
      if (!en_q) begin
        state_q  <= IDLE;
        out_port <= sw_q;
        out_src  <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (grant) begin
`ifdef DEBPORT_ARB_TAG_EN
              out_port <= {win_d, win_byte[DATA_W-3:0]};
`else
              out_port <= win_byte;
`endif
              out_src     <= win_d;
              ack[win_d]  <= 1'b1;
              ptr_q       <= win_d;
              last_q      <= win_d;
              hold_q      <= de - DWELL_W'(1);
              state_q     <= HOLD;
            end
          end
          HOLD: begin
            if (hold_q == '0) state_q <= IDLE;
            else hold_q <= hold_q - DWELL_W'(1);
          end
        endcase
      end
    end
  end

endmodule
